// File: rtl/xalu_ise_pkg.sv
// Shared definitions for the xalu_ise issue/response stage.
//   - CUSTOM_0..CUSTOM_3 : 2-bit custom opcode selectors (req_fn[1:0])
//   - state_t            : issue-stage FSM states
//   - XLEN_DEFAULT       : default operand/result width
//   - req_t              : request record at the default widths
package xalu_ise_pkg;

   localparam int unsigned XLEN_DEFAULT  = 32;
   localparam int unsigned TAG_W_DEFAULT = 5;

   localparam logic [1:0] CUSTOM_0 = 2'd0;
   localparam logic [1:0] CUSTOM_1 = 2'd1;
   localparam logic [1:0] CUSTOM_2 = 2'd2;
   localparam logic [1:0] CUSTOM_3 = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef struct packed {
      logic [5:0]               fn;
      logic [6:0]               imm;
      logic [XLEN_DEFAULT-1:0]  rs1;
      logic [XLEN_DEFAULT-1:0]  rs2;
      logic [TAG_W_DEFAULT-1:0] tag;
   } req_t;

endpackage

// File: rtl/xalu_ise_perf_cnt.sv
// Issued/illegal operation counters for the xalu_ise issue stage.
// Only instantiated when XALU_ISE_PERF_CNT_EN is defined.
//   clk, rst_n   : clock, asynchronous active-low reset
//   inc_issue    : one-cycle pulse per accepted request
//   inc_illegal  : one-cycle pulse per captured illegal result
//   cnt_issue    : 32-bit wrapping issue count
//   cnt_illegal  : 32-bit wrapping illegal count
module xalu_ise_perf_cnt (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc_issue,
   input  logic        inc_illegal,
   output logic [31:0] cnt_issue,
   output logic [31:0] cnt_illegal
);

   logic [31:0] issue_q, illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_q   <= '0;
         illegal_q <= '0;
      end else begin
         if (inc_issue)   issue_q   <= issue_q + 32'd1;
         if (inc_illegal) illegal_q <= illegal_q + 32'd1;
      end
   end

   assign cnt_issue   = issue_q;
   assign cnt_illegal = illegal_q;

endmodule

// File: rtl/xalu_ise_issue.sv
// Issue/response stage between the execute pipeline and the xalu_ise datapath.
// Registers a request, drives the combinational ALU for EXEC_LAT cycles, captures
// its result and offers it to writeback over valid/ready. Flush kills any in-flight op.
//   ise_clk, ise_rst : clock, asynchronous active-low reset
//   flush            : synchronous kill of the in-flight op
//   req_*            : request handshake and operands from execute
//   ise_*            : registered operands to / result from the ALU
//   rsp_*            : response handshake and result to writeback
//   cnt_issue/illegal: perf counters, present only with XALU_ISE_PERF_CNT_EN defined,
//                      otherwise tied to zero
module xalu_ise_issue
   import xalu_ise_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEFAULT,
   parameter int unsigned EXEC_LAT = 1,
   parameter int unsigned TAG_W    = TAG_W_DEFAULT
) (
   input  logic             ise_clk,
   input  logic             ise_rst,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [5:0]       req_fn,
   input  logic [6:0]       req_imm,
   input  logic [XLEN-1:0]  req_rs1,
   input  logic [XLEN-1:0]  req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   output logic [5:0]       ise_fn,
   output logic [6:0]       ise_imm,
   output logic [XLEN-1:0]  ise_in1,
   output logic [XLEN-1:0]  ise_in2,
   output logic             ise_val,
   input  logic             ise_oval,
   input  logic [XLEN-1:0]  ise_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [XLEN-1:0]  rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_illegal,
   output logic [31:0]      cnt_issue,
   output logic [31:0]      cnt_illegal
);

   if (EXEC_LAT < 1 || EXEC_LAT > 15) begin : g_bad_lat
      $error("EXEC_LAT must be in 1..15");
   end

   typedef struct packed {
      logic [5:0]       fn;
      logic [6:0]       imm;
      logic [XLEN-1:0]  rs1;
      logic [XLEN-1:0]  rs2;
      logic [TAG_W-1:0] tag;
   } op_t;

   localparam logic [3:0] LatInit = 4'(EXEC_LAT - 1);

   state_t           state_q, state_d;
   op_t              op_q, op_d;
   logic [3:0]       lat_q, lat_d;
   logic [XLEN-1:0]  data_q, data_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             ill_q, ill_d;
   logic             accept, capture;

   assign req_ready = !flush && (state_q == IDLE || (state_q == RESP && rsp_ready));
   assign accept    = req_valid && req_ready;
   // A flush on the last EXEC cycle kills the op before its result is captured.
   assign capture   = (state_q == EXEC) && (lat_q == 4'd0) && !flush;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      lat_d   = lat_q;
      data_d  = data_q;
      tag_d   = tag_q;
      ill_d   = ill_q;

      unique case (state_q)
         IDLE: if (accept) state_d = EXEC;
         EXEC: begin
            if (lat_q != 4'd0) lat_d   = lat_q - 4'd1;
            else               state_d = RESP;
         end
         RESP: begin
            if (accept)         state_d = EXEC;
            else if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (capture) begin
         data_d = ise_oval ? ise_out : '0;
         ill_d  = !ise_oval;
         tag_d  = op_q.tag;
      end

      // Operand registers only change on accept, so the ALU inputs stay quiet otherwise.
      if (accept) begin
         op_d  = '{fn: req_fn, imm: req_imm, rs1: req_rs1, rs2: req_rs2, tag: req_tag};
         lat_d = LatInit;
      end

      if (flush) state_d = IDLE;
   end

   always_ff @(posedge ise_clk or negedge ise_rst) begin
      if (!ise_rst) begin
         state_q <= IDLE;
         op_q    <= '0;
         lat_q   <= '0;
         data_q  <= '0;
         tag_q   <= '0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         lat_q   <= lat_d;
         data_q  <= data_d;
         tag_q   <= tag_d;
         ill_q   <= ill_d;
      end
   end

   assign ise_fn      = op_q.fn;
   assign ise_imm     = op_q.imm;
   assign ise_in1     = op_q.rs1;
   assign ise_in2     = op_q.rs2;
   assign ise_val     = (state_q == EXEC);
   assign rsp_valid   = (state_q == RESP);
   assign rsp_data    = data_q;
   assign rsp_tag     = tag_q;
   assign rsp_illegal = ill_q;

`ifdef XALU_ISE_PERF_CNT_EN
   xalu_ise_perf_cnt u_perf_cnt (
      .clk         (ise_clk),
      .rst_n       (ise_rst),
      .inc_issue   (accept),
      .inc_illegal (capture && !ise_oval),
      .cnt_issue   (cnt_issue),
      .cnt_illegal (cnt_illegal)
   );
`else
   assign cnt_issue   = '0;
   assign cnt_illegal = '0;
`endif

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Bench for xalu_ise_issue: two instances (EXEC_LAT = 1 and 4) share one stimulus
// stream; each is compared every cycle against a transaction-level reference.
// Counter expectations follow XALU_ISE_PERF_CNT_EN.
module tb_xalu_ise_issue;
   import xalu_ise_pkg::*;

`ifdef XALU_ISE_PERF_CNT_EN
   localparam bit PerfEn = 1'b1;
`else
   localparam bit PerfEn = 1'b0;
`endif
   localparam logic [6:0] IllImm = 7'b1111000;

   logic        clk = 1'b0;
   logic        rst_n, flush, req_valid, rsp_ready;
   logic [5:0]  req_fn;
   logic [6:0]  req_imm;
   logic [31:0] req_rs1, req_rs2;
   logic [4:0]  req_tag;

   logic        req_ready [2];
   logic [5:0]  ise_fn [2];
   logic [6:0]  ise_imm [2];
   logic [31:0] ise_in1 [2];
   logic [31:0] ise_in2 [2];
   logic        ise_val [2];
   logic        ise_oval [2];
   logic [31:0] ise_out [2];
   logic        rsp_valid [2];
   logic [31:0] rsp_data [2];
   logic [4:0]  rsp_tag [2];
   logic        rsp_illegal [2];
   logic [31:0] cnt_issue [2];
   logic [31:0] cnt_illegal [2];

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      // ALU stub: XOR of the operands; funct7 1111000 is the one unknown encoding.
      assign ise_oval[g] = (ise_imm[g] != IllImm);
      assign ise_out[g]  = ise_in1[g] ^ ise_in2[g];

      xalu_ise_issue #(
         .XLEN     (32),
         .EXEC_LAT ((g == 0) ? 1 : 4),
         .TAG_W    (5)
      ) u_dut (
         .ise_clk     (clk),
         .ise_rst     (rst_n),
         .flush       (flush),
         .req_valid   (req_valid),
         .req_ready   (req_ready[g]),
         .req_fn      (req_fn),
         .req_imm     (req_imm),
         .req_rs1     (req_rs1),
         .req_rs2     (req_rs2),
         .req_tag     (req_tag),
         .ise_fn      (ise_fn[g]),
         .ise_imm     (ise_imm[g]),
         .ise_in1     (ise_in1[g]),
         .ise_in2     (ise_in2[g]),
         .ise_val     (ise_val[g]),
         .ise_oval    (ise_oval[g]),
         .ise_out     (ise_out[g]),
         .rsp_valid   (rsp_valid[g]),
         .rsp_ready   (rsp_ready),
         .rsp_data    (rsp_data[g]),
         .rsp_tag     (rsp_tag[g]),
         .rsp_illegal (rsp_illegal[g]),
         .cnt_issue   (cnt_issue[g]),
         .cnt_illegal (cnt_illegal[g])
      );
   end

   // Reference: per instance, remaining ALU cycles of the current op, whether a
   // response is on offer, the last issued op and the last delivered result.
   int          m_exec_left [2];
   bit          m_resp [2];
   req_t        m_op [2];
   logic [31:0] m_data [2];
   logic [4:0]  m_tag [2];
   bit          m_ill [2];
   logic [31:0] m_iss [2];
   logic [31:0] m_illc [2];

   function automatic int lat_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_ready(input int i);
      if (flush) return 1'b0;
      return (m_exec_left[i] == 0 && !m_resp[i]) || (m_resp[i] && rsp_ready);
   endfunction

   task automatic m_reset(input int i);
      m_exec_left[i] = 0;
      m_resp[i]      = 1'b0;
      m_op[i]        = '0;
      m_data[i]      = '0;
      m_tag[i]       = '0;
      m_ill[i]       = 1'b0;
      m_iss[i]       = '0;
      m_illc[i]      = '0;
   endtask

   task automatic m_step(input int i);
      bit acc;
      bit legal;
      if (!rst_n) begin
         m_reset(i);
         return;
      end
      acc = req_valid && m_ready(i);
      if (flush) begin
         m_exec_left[i] = 0;
         m_resp[i]      = 1'b0;
      end else begin
         if (m_resp[i] && rsp_ready) m_resp[i] = 1'b0;
         if (m_exec_left[i] > 0) begin
            m_exec_left[i]--;
            if (m_exec_left[i] == 0) begin
               legal     = (m_op[i].imm != IllImm);
               m_resp[i] = 1'b1;
               m_data[i] = legal ? (m_op[i].rs1 ^ m_op[i].rs2) : 32'h0;
               m_ill[i]  = !legal;
               m_tag[i]  = m_op[i].tag;
               if (!legal) m_illc[i]++;
            end
         end
      end
      if (acc) begin
         m_op[i]        = '{fn: req_fn, imm: req_imm, rs1: req_rs1, rs2: req_rs2, tag: req_tag};
         m_exec_left[i] = lat_of(i);
         m_iss[i]++;
      end
   endtask

   task automatic compare_all();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("L%0d req_ready", lat_of(i)), 64'(req_ready[i]), 64'(m_ready(i)));
         check($sformatf("L%0d ise_val", lat_of(i)), 64'(ise_val[i]), 64'(m_exec_left[i] > 0));
         check($sformatf("L%0d ise_fn", lat_of(i)), 64'(ise_fn[i]), 64'(m_op[i].fn));
         check($sformatf("L%0d ise_imm", lat_of(i)), 64'(ise_imm[i]), 64'(m_op[i].imm));
         check($sformatf("L%0d ise_in1", lat_of(i)), 64'(ise_in1[i]), 64'(m_op[i].rs1));
         check($sformatf("L%0d ise_in2", lat_of(i)), 64'(ise_in2[i]), 64'(m_op[i].rs2));
         check($sformatf("L%0d rsp_valid", lat_of(i)), 64'(rsp_valid[i]), 64'(m_resp[i]));
         check($sformatf("L%0d rsp_data", lat_of(i)), 64'(rsp_data[i]), 64'(m_data[i]));
         check($sformatf("L%0d rsp_tag", lat_of(i)), 64'(rsp_tag[i]), 64'(m_tag[i]));
         check($sformatf("L%0d rsp_illegal", lat_of(i)), 64'(rsp_illegal[i]), 64'(m_ill[i]));
         check($sformatf("L%0d cnt_issue", lat_of(i)), 64'(cnt_issue[i]),
               PerfEn ? 64'(m_iss[i]) : 64'h0);
         check($sformatf("L%0d cnt_illegal", lat_of(i)), 64'(cnt_illegal[i]),
               PerfEn ? 64'(m_illc[i]) : 64'h0);
      end
   endtask

   // One clock: drive at the falling edge, compare 1 time unit later, advance the model.
   task automatic cycle(input bit v, input logic [5:0] fn, input logic [6:0] imm,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tg,
                        input bit rdy, input bit fl);
      @(negedge clk);
      req_valid = v;
      req_fn    = fn;
      req_imm   = imm;
      req_rs1   = rs1;
      req_rs2   = rs2;
      req_tag   = tg;
      rsp_ready = rdy;
      flush     = fl;
      #1;
      compare_all();
      for (int i = 0; i < 2; i++) m_step(i);
   endtask

   task automatic idle(input bit rdy);
      cycle(1'b0, 6'($urandom), 7'($urandom), $urandom, $urandom, 5'($urandom), rdy, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      req_fn    = '0;
      req_imm   = '0;
      req_rs1   = '0;
      req_rs2   = '0;
      req_tag   = '0;
      for (int i = 0; i < 2; i++) m_reset(i);

      repeat (3) idle(1'b0);
      rst_n = 1'b1;
      idle(1'b0);

      // Legal op, then back-pressure, then back-to-back illegal op.
      cycle(1'b1, {4'b0000, CUSTOM_2}, 7'b0000000, 32'hA5A5_0000, 32'h0000_5A5A, 5'd7,
            1'b0, 1'b0);
      repeat (6) idle(1'b0);
      cycle(1'b1, {4'b0000, CUSTOM_0}, IllImm, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3,
            1'b1, 1'b0);
      repeat (6) idle(1'b1);

      // Flush during the second EXEC cycle of the long-latency instance.
      cycle(1'b1, {4'b0001, CUSTOM_1}, 7'b0000001, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd9,
            1'b1, 1'b0);
      idle(1'b1);
      cycle(1'b1, {4'b0000, CUSTOM_3}, 7'b0000010, 32'h1111_1111, 32'h2222_2222, 5'd4,
            1'b1, 1'b1);
      repeat (2) idle(1'b1);
      cycle(1'b1, {4'b0000, CUSTOM_3}, 7'b0000011, 32'h3333_0000, 32'h0000_4444, 5'd12,
            1'b1, 1'b0);
      repeat (6) idle(1'b1);

      // Random traffic.
      repeat (1500) begin
         cycle($urandom_range(0, 2) != 0, 6'($urandom),
               ($urandom_range(0, 3) == 0) ? IllImm : 7'($urandom),
               $urandom, $urandom, 5'($urandom),
               $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
      end
      repeat (6) idle(1'b1);

      // Asynchronous reset between clock edges while a response is held.
      cycle(1'b1, {4'b0000, CUSTOM_2}, 7'b0000101, 32'hCAFE_0001, 32'h0000_F00D, 5'd21,
            1'b0, 1'b0);
      repeat (6) idle(1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("arst rsp_valid", 64'(rsp_valid[i]), 64'h0);
         check("arst rsp_data", 64'(rsp_data[i]), 64'h0);
         check("arst rsp_tag", 64'(rsp_tag[i]), 64'h0);
         check("arst rsp_illegal", 64'(rsp_illegal[i]), 64'h0);
         check("arst ise_val", 64'(ise_val[i]), 64'h0);
         check("arst ise_in1", 64'(ise_in1[i]), 64'h0);
         check("arst ise_in2", 64'(ise_in2[i]), 64'h0);
         check("arst ise_fn", 64'(ise_fn[i]), 64'h0);
         check("arst cnt_issue", 64'(cnt_issue[i]), 64'h0);
         check("arst cnt_illegal", 64'(cnt_illegal[i]), 64'h0);
         m_reset(i);
      end
      idle(1'b0);
      rst_n = 1'b1;
      idle(1'b0);
      for (int i = 0; i < 2; i++) begin
         check("post-rst cnt_issue", 64'(cnt_issue[i]), 64'h0);
         check("post-rst req_ready", 64'(req_ready[i]), 64'h1);
      end
      cycle(1'b1, {4'b0000, CUSTOM_1}, 7'b0000000, 32'h0000_FFFF, 32'hFFFF_0000, 5'd30,
            1'b1, 1'b0);
      repeat (6) idle(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
